// File: rtl/spi_slave_single_ss.sv
// SPI responder: oversamples sclk/ss_n/mosi into clk, shifts MSB-first in all four modes, multi-frame bursts.
// Optional: define SPI_SLAVE_UNDERRUN_EN to add the tx_underrun pulse output.
module spi_slave_single_ss #(
  parameter int FRAME_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [FRAME_WIDTH-1:0] din,
  input  logic                   tx_load,
  output logic                   tx_ready,
  output logic [FRAME_WIDTH-1:0] dout,
  output logic                   rx_done,
  input  logic                   sclk,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic                   tx_underrun
`endif
);

  localparam int CNT_W = (FRAME_WIDTH > 2) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WIDTH - 1);
  localparam logic [FRAME_WIDTH-1:0] FRAME_ZERO = {FRAME_WIDTH{1'b0}};
  localparam logic [FRAME_WIDTH-2:0] RX_ZERO    = {(FRAME_WIDTH-1){1'b0}};
  localparam logic [SYNC_STAGES-1:0] SYNC_LOW   = {SYNC_STAGES{1'b0}};
  localparam logic [SYNC_STAGES-1:0] SYNC_HIGH  = {SYNC_STAGES{1'b1}};

  logic [SYNC_STAGES-1:0] sclk_sync_r, ss_sync_r, mosi_sync_r;
  logic                   sclk_s, ss_s, mosi_s, sclk_prev_r;
  logic                   lead_s, trail_s, sample_s, shift_edge_s, load_s;
  logic [0:0]             state_r, state_n;
  logic [1:0]             mode_r, mode_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [FRAME_WIDTH-2:0] rx_shift_r, rx_shift_n;
  logic [FRAME_WIDTH-1:0] rx_word_s;
  logic [FRAME_WIDTH-1:0] tx_shift_r, tx_shift_n, tx_buf_r, tx_buf_n, dout_r, dout_n;
  logic                   tx_ready_r, tx_ready_n, rx_done_r, rx_done_n, miso_r, miso_n;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign ss_s   = ss_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

  // Leading edge leaves CPOL, trailing edge returns to it; CPHA picks which one samples.
  assign lead_s       = mode_r[1] ? (sclk_prev_r & ~sclk_s) : (~sclk_prev_r & sclk_s);
  assign trail_s      = mode_r[1] ? (~sclk_prev_r & sclk_s) : (sclk_prev_r & ~sclk_s);
  assign sample_s     = mode_r[0] ? trail_s : lead_s;
  assign shift_edge_s = mode_r[0] ? lead_s : trail_s;
  assign rx_word_s    = {rx_shift_r, mosi_s};

  // Next-state logic for the burst FSM, RX/TX shifters and the one-entry TX buffer.
  always_comb begin
    state_n    = state_r;
    mode_n     = mode_r;
    cnt_n      = cnt_r;
    rx_shift_n = rx_shift_r;
    tx_shift_n = tx_shift_r;
    tx_buf_n   = tx_buf_r;
    tx_ready_n = tx_ready_r;
    dout_n     = dout_r;
    rx_done_n  = 1'b0;
    load_s     = 1'b0;
    miso_n     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!ss_s) begin
          state_n = ST_ACTIVE;
          mode_n  = mode;
          load_s  = ~mode[0];
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_s) begin
          state_n    = ST_IDLE;
          cnt_n      = CNT_ZERO;
          rx_shift_n = RX_ZERO;
          tx_shift_n = FRAME_ZERO;
        end else if (sample_s) begin
          if (cnt_r == CNT_LAST) begin
            dout_n    = rx_word_s;
            rx_done_n = 1'b1;
            cnt_n     = CNT_ZERO;
          end else begin
            rx_shift_n = rx_word_s[FRAME_WIDTH-2:0];
            cnt_n      = cnt_r + CNT_ONE;
          end
        end else if (shift_edge_s) begin
          // A zero count on the shift edge marks a frame boundary: fetch the next word.
          if (cnt_r == CNT_ZERO) begin
            load_s = 1'b1;
          end else begin
            tx_shift_n = {tx_shift_r[FRAME_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_n = ST_ACTIVE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (load_s) begin
      tx_ready_n = 1'b1;
      if (!tx_ready_r) begin
        tx_shift_n = tx_buf_r;
      end else if (tx_load) begin
        tx_shift_n = din;
      end else begin
        tx_shift_n = FRAME_ZERO;
      end
    end else if (tx_load && tx_ready_r) begin
      tx_buf_n   = din;
      tx_ready_n = 1'b0;
    end else begin
      tx_buf_n = tx_buf_r;
    end

    miso_n = (state_n == ST_ACTIVE) ? tx_shift_n[FRAME_WIDTH-1] : 1'b0;
  end

  // Synchronizers and all state/output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_r <= SYNC_LOW;
      ss_sync_r   <= SYNC_HIGH;
      mosi_sync_r <= SYNC_LOW;
      sclk_prev_r <= 1'b0;
      state_r     <= ST_IDLE;
      mode_r      <= 2'b00;
      cnt_r       <= CNT_ZERO;
      rx_shift_r  <= RX_ZERO;
      tx_shift_r  <= FRAME_ZERO;
      tx_buf_r    <= FRAME_ZERO;
      tx_ready_r  <= 1'b1;
      dout_r      <= FRAME_ZERO;
      rx_done_r   <= 1'b0;
      miso_r      <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_prev_r <= sclk_s;
      state_r     <= state_n;
      mode_r      <= mode_n;
      cnt_r       <= cnt_n;
      rx_shift_r  <= rx_shift_n;
      tx_shift_r  <= tx_shift_n;
      tx_buf_r    <= tx_buf_n;
      tx_ready_r  <= tx_ready_n;
      dout_r      <= dout_n;
      rx_done_r   <= rx_done_n;
      miso_r      <= miso_n;
    end
  end

  assign tx_ready = tx_ready_r;
  assign dout     = dout_r;
  assign rx_done  = rx_done_r;
  assign miso     = miso_r;

`ifdef SPI_SLAVE_UNDERRUN_EN
  logic underrun_r;

  // Flags loads that found the buffer empty with no same-cycle refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= load_s & tx_ready_r & ~tx_load;
    end
  end

  assign tx_underrun = underrun_r;
`endif

endmodule
